// File: rtl/sd_cic_decimator.sv
// sd_cic_decimator
//   Delta-sigma (1-bit PDM) to PCM demodulator: a 3rd-order CIC decimator
//   (three integrators at clock rate, three combs at the decimated rate),
//   followed by an arithmetic right shift and saturation to OUT_W signed bits.
//
//   Optional build macro: SD_CIC_WARMUP_MASK_EN
//     When defined, the first three decimated samples after reset (which are
//     transients because the comb delays start at zero) are not strobed and
//     audio_o stays at 0 until the fourth tick.
//
//   Integrators and combs rely on two's-complement wrap-around; the comb
//   differences recover the exact result as long as the true comb output
//   fits in ACC_W bits, which ACC_W = 3*DECIM_LOG2 + 2 guarantees.
module sd_cic_decimator #(
  parameter int DECIM_LOG2 = 10,
  parameter int OUT_W      = 14
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wave_i,
  output logic signed [OUT_W-1:0] audio_o,
  output logic                    audio_valid_o
);

  localparam int ACC_W = 3 * DECIM_LOG2 + 2;
  localparam int SHIFT = 3 * DECIM_LOG2 - (OUT_W - 1);

  // Saturation bounds expressed at accumulator width so the compare is signed.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        [DECIM_LOG2-1:0] cnt_q,  cnt_d;
  logic signed [ACC_W-1:0]      int1_q, int1_d;
  logic signed [ACC_W-1:0]      int2_q, int2_d;
  logic signed [ACC_W-1:0]      int3_q, int3_d;
  logic signed [ACC_W-1:0]      d1_q,   d1_d;
  logic signed [ACC_W-1:0]      d2_q,   d2_d;
  logic signed [ACC_W-1:0]      d3_q,   d3_d;
  logic signed [OUT_W-1:0]      audio_q, audio_d;
  logic                         valid_q, valid_d;

  // ---------------------------------------------------------------------------
  // Combinational datapath
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] c1, c2, c3;
  logic signed [ACC_W-1:0] s;
  logic signed [OUT_W-1:0] sat;
  logic                    tick;
  logic                    strobe_en;

  // Map the 1-bit stream to +1 / -1 at accumulator width.
  always_comb begin
    x = wave_i ? ACC_W'(1) : {ACC_W{1'b1}};
  end

  // Decimation tick fires in the last cycle of each R-cycle frame.
  always_comb begin
    tick  = (cnt_q == {DECIM_LOG2{1'b1}});
    cnt_d = cnt_q + DECIM_LOG2'(1);
  end

  // Pipelined integrators; each stage adds the previous stage's registered value.
  always_comb begin
    int1_d = int1_q + x;
    int2_d = int2_q + int1_q;
    int3_d = int3_q + int2_q;
  end

  // Comb chain on the current int3 sample; delays only advance on tick.
  always_comb begin
    c1 = int3_q - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    if (tick) begin
      d1_d = int3_q;
      d2_d = c1;
      d3_d = c2;
    end
  end

  // Floor scaling by arithmetic shift, then clamp to the OUT_W signed range.
  always_comb begin
    s = c3 >>> SHIFT;
    if (s > SAT_MAX) begin
      sat = SAT_MAX[OUT_W-1:0];
    end else if (s < SAT_MIN) begin
      sat = SAT_MIN[OUT_W-1:0];
    end else begin
      sat = s[OUT_W-1:0];
    end
  end

`ifdef SD_CIC_WARMUP_MASK_EN
  // Warm-up counter: counts ticks up to 3, after which strobes are released.
  logic [1:0] warm_q, warm_d;

  // Advance the warm-up counter on each tick until it saturates.
  always_comb begin
    warm_d = warm_q;
    if (tick && (warm_q != 2'd3)) begin
      warm_d = warm_q + 2'd1;
    end
    strobe_en = (warm_q == 2'd3);
  end

  // Warm-up counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      warm_q <= 2'd0;
    end else begin
      warm_q <= warm_d;
    end
  end
`else
  // Every tick is strobed, including the start-up transients.
  always_comb begin
    strobe_en = 1'b1;
  end
`endif

  // Output register update: new sample and one-cycle strobe on unmasked ticks.
  always_comb begin
    audio_d = audio_q;
    valid_d = 1'b0;
    if (tick && strobe_en) begin
      audio_d = sat;
      valid_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Counter, integrators, comb delays and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      int1_q  <= '0;
      int2_q  <= '0;
      int3_q  <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      audio_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      int1_q  <= int1_d;
      int2_q  <= int2_d;
      int3_q  <= int3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      audio_q <= audio_d;
      valid_q <= valid_d;
    end
  end

  assign audio_o       = audio_q;
  assign audio_valid_o = valid_q;

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Testbench for sd_cic_decimator.
// The reference model computes each decimated sample directly from the input
// history: the pipelined triple integrator after n clocks equals
// sum_j x_j * C(n-1-j, 2), taken at the end of every R-cycle frame, followed by
// a third difference across frames, floor shift and clamp. Exact 64-bit
// arithmetic is used, so no wrap-around is modelled.
module tb_sd_cic_decimator;

  localparam int DL    = 10;
  localparam int OW    = 14;
  localparam int R     = 1 << DL;
  localparam int SHIFT = 3 * DL - (OW - 1);
  localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW - 1));

  logic                 clk_i  = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 wave_i = 1'b0;
  logic signed [OW-1:0] audio_o;
  logic                 audio_valid_o;

  sd_cic_decimator #(.DECIM_LOG2(DL), .OUT_W(OW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wave_i        (wave_i),
    .audio_o       (audio_o),
    .audio_valid_o (audio_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int     checks = 0;
  int     errors = 0;
  bit     hist[$];     // input bits since reset release, x_j at index j
  longint vq[$];       // frame-end integrator samples, vq[k-1] = v_k
  int     e;           // clock edges since reset release
  longint exp_audio;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, e, act, exp);
    end
  endtask

  // Value of the third integrator after n clock edges.
  function automatic longint v_of(input int n);
    longint acc = 0;
    for (int j = 0; j < n; j++) begin
      longint w = longint'(n - 1 - j) * longint'(n - 2 - j) / 2;
      acc += hist[j] ? w : -w;
    end
    return acc;
  endfunction

  function automatic longint getv(input int k);
    if (k < 1) return 0;
    return vq[k-1];
  endfunction

  // Assert reset at the current negedge, check immediate clear, release 3 cycles later.
  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    check("reset_valid", longint'(audio_valid_o), 0);
    check("reset_audio", longint'(audio_o), 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    hist.delete();
    vq.delete();
    e = 0;
    exp_audio = 0;
  endtask

  // Run n cycles with a repeating pattern; compare outputs every cycle.
  // Called and returns at a negedge.
  task automatic run(input bit [7:0] pat, input int plen, input int n,
                     input bit lit_en, input longint lit);
    for (int i = 0; i < n; i++) begin
      bit exp_valid = 1'b0;
      if (e > 0 && (e % R) == 0) begin
        int     k = e / R;
        longint c3, s;
        bit     masked = 1'b0;
        vq.push_back(v_of(k * R - 1));
        c3 = getv(k) - 3 * getv(k - 1) + 3 * getv(k - 2) - getv(k - 3);
        s  = c3 >>> SHIFT;
        if (s > OMAX) s = OMAX;
        if (s < OMIN) s = OMIN;
`ifdef SD_CIC_WARMUP_MASK_EN
        masked = (k < 4);
`endif
        if (!masked) begin
          exp_valid = 1'b1;
          exp_audio = s;
        end
        if (lit_en && k >= 4) begin
          check("model_pin", exp_audio, lit);
          check("dut_pin", longint'(audio_o), lit);
        end
      end
      check("valid", longint'(audio_valid_o), longint'(exp_valid));
      check("audio", longint'(audio_o), exp_audio);
      wave_i = pat[e % plen];
      hist.push_back(wave_i);
      e++;
      @(negedge clk_i);
    end
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();
    run(8'b1, 1, 6 * R + 2, 1'b1, 8191);        // constant ones
    do_reset();
    run(8'b0, 1, 6 * R + 2, 1'b1, -8192);       // constant zeros
    do_reset();
    run(8'b01, 2, 5 * R + 2, 1'b1, 0);          // 1,0,1,0
    do_reset();
    run(8'b0111, 4, 5 * R + 2, 1'b1, 4096);     // 1,1,1,0
    do_reset();
    run(8'b0001, 4, 5 * R + 2, 1'b1, -4096);    // 1,0,0,0
    do_reset();
    run(8'b1, 1, R + 500, 1'b0, 0);             // stop mid-frame at cnt = 500
    do_reset();                                 // mid-run reset, 3 cycles
    run(8'b1, 1, 5 * R + 2, 1'b1, 8191);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_cic_decimator.md
Name: sd_cic_decimator

Overview:
- Delta-sigma demodulator. Recovers PCM audio from the 1-bit density stream produced by the modulator.
- Structure: 3rd-order CIC decimator (3 integrators at clock rate, 3 combs at decimated rate), then scaling and saturation to 14-bit signed.
- Used as the loop-back/verification path for the audio output, and as a receiver for an external 1-bit PDM source.
- Output format matches the modulator input: audio_o with a one-cycle audio_valid_o strobe.

Parameters:
- DECIM_LOG2, 10, log2 of decimation ratio R (R = 1024, giving 48.83 kHz at 50 MHz). Legal range 5..12.
- OUT_W, 14, output sample width (signed).
- Derived localparam ACC_W = 3*DECIM_LOG2 + 2 (32 at default): integrator/comb width.
- Derived localparam SHIFT = 3*DECIM_LOG2 - (OUT_W-1) (17 at default).

Ports:
- clk_i  input  1  system clock, 50 MHz
- rst_ni  input  1  asynchronous active-low reset
- wave_i  input  1  1-bit delta-sigma stream, one bit per clk_i cycle
- audio_o  output  OUT_W  signed decimated sample, held between strobes
- audio_valid_o  output  1  one-cycle strobe, audio_o updated in this cycle

Behaviour:
- Reset:
  - One clock. Reset is asynchronous and active-low; all flops clear immediately on rst_ni low.
  - Cleared state: int1..3, d1..3, decimation counter, audio_o = 0, audio_valid_o = 0.
- Input mapping: x = +1 when wave_i = 1, -1 when wave_i = 0, sign-extended to ACC_W.
- Integrators (every cycle, registered, pipelined form):
  - int1 <= int1 + x
  - int2 <= int2 + int1
  - int3 <= int3 + int2
  - Two's-complement wrap-around is required. No saturation in integrators or combs.
- Decimation counter:
  - DECIM_LOG2 bits, increments every cycle, wraps from R-1 to 0.
  - tick = (cnt == R-1).
- Combs (evaluated combinationally only on tick, registered on the tick edge):
  - c1 = int3 - d1
  - c2 = c1 - d2
  - c3 = c2 - d3
  - On tick: d1 <= int3, d2 <= c1, d3 <= c2.
- Scaling and saturation:
  - s = c3 >>> SHIFT (arithmetic shift, floor).
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Full-scale +1 density gives +8192, which clamps to 8191.
- Output timing:
  - audio_o <= sat(s) and audio_valid_o <= 1 on the tick edge, i.e. visible in the cycle after cnt == R-1.
  - audio_valid_o is low in all other cycles.
  - First strobe occurs R cycles after reset release; strobes thereafter are exactly R cycles apart.
- Warm-up:
  - The first 3 outputs after reset are transient, since the comb delays start at zero.
  - Without the optional feature they are still strobed.
- Reset mid-operation: immediate clear of all state. A strobe in flight is lost, and the counter restarts at 0.
- Steady-state DC gain: R^3 / 2^SHIFT = 8192 per unit density. Output = round-down(8192 * (2p - 1)), where p is the ones-density, then clamped.

Optional Feature:
- Macro: SD_CIC_WARMUP_MASK_EN.
- Defined:
  - A 2-bit warm-up counter suppresses audio_valid_o (forced 0, audio_o held at 0) for the first 3 ticks after reset.
  - The first visible strobe is tick 4, at cycle 4R after reset release.
  - The counter saturates at 3 and is cleared by rst_ni.
- Undefined: no warm-up counter; every tick strobes, including transients.

Test Plan:
- Reset, then wave_i = 1 constantly -> audio_valid_o pulses exactly every 1024 cycles, first pulse at cycle 1024. After 4th strobe, audio_o = 8191 (saturated) on every strobe.
- wave_i = 0 constantly -> after 4th strobe, audio_o = -8192 on every strobe. No wrap artefacts after 2^20 cycles.
- wave_i alternating 1,0 -> after 4th strobe, audio_o = 0 exactly.
- wave_i repeating 1,1,1,0 (p = 0.75) -> after 4th strobe, audio_o = 4096. Pattern 1,0,0,0 -> audio_o = -4096.
- Mid-run reset: assert rst_ni low for 3 cycles at cnt = 500 -> outputs 0 immediately. Next strobe 1024 cycles after release; no strobe near the pre-reset schedule.
- With SD_CIC_WARMUP_MASK_EN, constant 1 -> no strobe before cycle 4096. First strobe at cycle 4096 with audio_o = 8191. Without the macro, strobes occur at 1024/2048/3072 with transient values.
